fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage of the simple Tomasulo CPU.
- Issues sequential read requests to the instruction port of the memory controller.
- Accepts tagged responses in program order and pushes {pc, instruction} entries into the instruction-buffer FIFO.
- Redirects to a branch target on request from dispatch and discards all stale in-flight responses.

Parameters:
- RESET_PC, 16'h0000, first fetch address after reset.
- MAX_OUTSTANDING, 4, maximum issued-but-not-accepted requests; must be 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- ib_push  out  1  push strobe to the instruction buffer.
- ib_push_data  out  32  buffer entry: [31:16] = instruction address, [15:0] = instruction word.
- ib_full  in  1  instruction buffer full; a push is illegal while high.
- imem_raddr  out  16  request address to the memory controller.
- imem_re  out  1  request valid; the memory controller accepts one request per cycle while high.
- imem_raddr_out  in  16  address tag of the returned word.
- imem_data_out  in  16  returned instruction word.
- imem_ready  in  1  response valid this cycle; single-cycle and not held.
- branch_taken  in  1  redirect strobe from dispatch.
- branch_target  in  16  redirect address; valid when branch_taken is high.

Behaviour:
- State:
  - req_pc: next address to issue.
  - exp_pc: next address to accept.
  - outstanding = req_pc - exp_pc, computed modulo 2^16.
- Addressing: word-addressed; increment by 1; wraps from 16'hFFFF to 16'h0000.
- Reset (rst_n=0 at a clock edge):
  - req_pc and exp_pc load RESET_PC.
  - Registered outputs clear: ib_push=0, ib_push_data=0, imem_re=0, imem_raddr=0.
  - Reset mid-operation abandons all in-flight requests. Responses arriving after reset are treated as stale (tag-mismatched) and dropped.
- Issue (registered outputs, one-cycle latency from state):
  - If outstanding < MAX_OUTSTANDING and no redirect or replay happens this cycle, drive imem_re=1 and imem_raddr=req_pc, then req_pc++.
  - Otherwise drive imem_re=0.
- Accept, checked each cycle with imem_ready=1:
  - Tag mismatch (imem_raddr_out != exp_pc): drop the response silently.
  - Tag match and ib_full=0: next cycle assert ib_push=1 with ib_push_data={exp_pc, imem_data_out}, then exp_pc++.
  - Tag match and ib_full=1 (replay): drop the response and set req_pc <= exp_pc. The missed word is re-fetched.
- ib_push is high for exactly one cycle per accepted word and low otherwise. Entries are pushed strictly in address order with no duplicates.
- Redirect (branch_taken=1):
  - req_pc and exp_pc load branch_target.
  - No push and no issue occur in that cycle.
  - All in-flight responses become stale; the tag check discards them.
  - Redirect has priority over accept, replay and issue in the same cycle.
  - A redirect to the current exp_pc is still a flush.
- Consecutive branch_taken cycles: the last target wins.
- The FIFO flush is owned by dispatch; fetch_unit never drives it.

Optional Feature:
- Macro FETCH_STATS_EN.
- Defined:
  - Adds outputs stat_pushed (16 bits) and stat_dropped (16 bits).
  - stat_pushed counts pushes.
  - stat_dropped counts tag-mismatched or replayed responses.
  - Both counters clear on reset and wrap on overflow.
- Undefined: these ports and counters do not exist, and core behaviour is identical.

Decomposition:
- Package fetch_pkg contains:
  - addr_t (16 bits) and instr_t (16 bits).
  - ib_entry_t, a packed struct {addr_t pc; instr_t instr} of 32 bits.
  - The constant RESET_PC_DEFAULT.
- Sub-module fetch_stat_counter: a 16-bit enabled, resettable wrap counter. It is instantiated twice, only under FETCH_STATS_EN.

Test Plan:
- Reset then free-run, with memory returning each word 2 cycles after request (word = 16'h1000 + addr) and ib_full=0 -> pushes {0000,1000}, {0001,1001}, {0002,1002}, ... one per cycle in steady state; never more than 4 outstanding.
- Hold ib_full=1 for 5 cycles while responses for addr 3..6 arrive -> no pushes. After release, the next push is {0003,1003} with no gaps or duplicates.
- Pulse branch_taken with branch_target=16'h0002 while addrs 5..7 are in flight -> responses 5..7 dropped; next push is {0002,1002}.
- Issue a redirect at the same cycle as a matching response and ib_full=0 -> no push that cycle; the redirect wins.
- Set branch_target=16'hFFFE -> pushes {FFFE,..}, {FFFF,..}, {0000,..}, showing address wrap.
- Assert rst_n=0 for one cycle with 3 requests in flight -> outputs clear. Late responses are dropped, and fetch restarts at RESET_PC. With FETCH_STATS_EN defined, stat_dropped increments for each late response.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package fetch_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [15:0] instr_t;

    // One instruction-buffer entry: address in the upper half, word in the lower half.
    typedef struct packed {
        addr_t  pc;
        instr_t instr;
    } ib_entry_t;

    localparam addr_t RESET_PC_DEFAULT        = 16'h0000;
    localparam int    MAX_OUTSTANDING_DEFAULT = 4;

    // Word-addressed increment; wraps from 16'hFFFF to 16'h0000.
    function automatic addr_t addr_inc(input addr_t a);
        return a + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_stat_counter.sv
// 16-bit event counter with enable and synchronous active-low clear; wraps on overflow.
// Latency: count reflects an enabled cycle one clock later.
// Backpressure: none; counts every enabled cycle.
module fetch_stat_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] count
);

    // Clear on reset, otherwise count enabled cycles modulo 2^16.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential requests to the instruction port, in-order tagged accept into the IB.
// Latency: issue and push are registered, one cycle after the deciding state/response.
// Backpressure: ib_full turns a matching response into a replay (re-fetch from exp_pc); at most
//               MAX_OUTSTANDING requests are in flight. Optional FETCH_STATS_EN adds stat counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter addr_t RESET_PC        = RESET_PC_DEFAULT,
    parameter int    MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
    input  logic      clk,
    input  logic      rst_n,
    output logic      ib_push,
    output ib_entry_t ib_push_data,
    input  logic      ib_full,
    output addr_t     imem_raddr,
    output logic      imem_re,
    input  addr_t     imem_raddr_out,
    input  instr_t    imem_data_out,
    input  logic      imem_ready,
    input  logic      branch_taken,
    input  addr_t     branch_target
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0] stat_pushed,
    output logic [15:0] stat_dropped
`endif
);

    localparam addr_t MAX_OUT = addr_t'(MAX_OUTSTANDING);

    addr_t req_pc;       // next address to request
    addr_t exp_pc;       // next address the buffer expects
    addr_t outstanding;  // requests issued but not yet accepted, modulo 2^16
    logic  tag_match;
    logic  accept;
    logic  replay;
    logic  issue;

    // Decide this cycle's accept/replay/issue; a redirect overrides all of them.
    always_comb begin
        outstanding = req_pc - exp_pc;
        tag_match   = imem_ready && (imem_raddr_out == exp_pc);
        accept      = tag_match && !ib_full && !branch_taken;
        replay      = tag_match &&  ib_full && !branch_taken;
        issue       = !branch_taken && !replay && (outstanding < MAX_OUT);
    end

    // Pointer and registered-output update; redirect flushes both pointers so in-flight tags go stale.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_pc       <= RESET_PC;
            exp_pc       <= RESET_PC;
            ib_push      <= 1'b0;
            ib_push_data <= '0;
            imem_re      <= 1'b0;
            imem_raddr   <= '0;
        end else if (branch_taken) begin
            req_pc  <= branch_target;
            exp_pc  <= branch_target;
            ib_push <= 1'b0;
            imem_re <= 1'b0;
        end else begin
            ib_push <= accept;
            imem_re <= issue;
            if (accept) begin
                ib_push_data <= '{pc: exp_pc, instr: imem_data_out};
                exp_pc       <= addr_inc(exp_pc);
            end
            if (replay) begin
                // Buffer could not take the word: rewind so it is requested again.
                req_pc <= exp_pc;
            end else if (issue) begin
                imem_raddr <= req_pc;
                req_pc     <= addr_inc(req_pc);
            end
        end
    end

`ifdef FETCH_STATS_EN
    // Any returned word that is not pushed (stale tag, replay, or lost to a redirect) counts as dropped.
    logic drop;
    assign drop = imem_ready && !accept;

    fetch_stat_counter u_stat_pushed (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .count (stat_pushed)
    );

    fetch_stat_counter u_stat_dropped (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (drop),
        .count (stat_dropped)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 2-cycle instruction memory (word = 16'h1000 + addr).
// Latency: n/a.
// Backpressure: ib_full and memory muting are driven by the directed sequence.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        ib_push;
    logic [31:0] ib_push_data;
    logic        ib_full;
    logic [15:0] imem_raddr;
    logic        imem_re;
    logic [15:0] imem_raddr_out;
    logic [15:0] imem_data_out;
    logic        imem_ready;
    logic        branch_taken;
    logic [15:0] branch_target;
`ifdef FETCH_STATS_EN
    logic [15:0] stat_pushed;
    logic [15:0] stat_dropped;
`endif

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ib_push        (ib_push),
        .ib_push_data   (ib_push_data),
        .ib_full        (ib_full),
        .imem_raddr     (imem_raddr),
        .imem_re        (imem_re),
        .imem_raddr_out (imem_raddr_out),
        .imem_data_out  (imem_data_out),
        .imem_ready     (imem_ready),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target)
`ifdef FETCH_STATS_EN
        ,
        .stat_pushed    (stat_pushed),
        .stat_dropped   (stat_dropped)
`endif
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          issue_cnt = 0;
    int          out_model = 0;
    logic        free_run = 1'b0;
    logic        mem_mute = 1'b0;
    logic [15:0] sb_pc    = 16'h0000;
    logic [31:0] push_log[$];
    int          push_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_pushes(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (push_log.size() < target && k < budget) begin
            step(1);
            k++;
        end
        check({tag, "_timeout"}, 32'(push_log.size() >= target), 32'd1);
    endtask

    task automatic redirect(input logic [15:0] tgt);
        branch_taken  = 1'b1;
        branch_target = tgt;
        step(1);
        branch_taken  = 1'b0;
    endtask

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory: request seen in cycle k is answered for exactly the edge ending cycle k+1.
    initial begin
        logic        s1_v, s2_v;
        logic [15:0] s1_a, s2_a;
        s1_v = 1'b0; s2_v = 1'b0; s1_a = '0; s2_a = '0;
        imem_ready = 1'b0; imem_raddr_out = '0; imem_data_out = '0;
        forever begin
            @(negedge clk);
            s2_v = s1_v;
            s2_a = s1_a;
            s1_v = imem_re;
            s1_a = imem_raddr;
            imem_ready     = s2_v && !mem_mute;
            imem_raddr_out = s2_a;
            imem_data_out  = s2_a + 16'h1000;
        end
    end

    // Scoreboard: every push must be the next expected address in order; redirects and resets retarget it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                check("rst_ib_push", {31'd0, ib_push}, 32'd0);
                check("rst_ib_push_data", ib_push_data, 32'd0);
                check("rst_imem_re", {31'd0, imem_re}, 32'd0);
                check("rst_imem_raddr", {16'd0, imem_raddr}, 32'd0);
                sb_pc     = 16'h0000;
                out_model = 0;
            end else if (branch_taken) begin
                check("redirect_no_push", {31'd0, ib_push}, 32'd0);
                check("redirect_no_issue", {31'd0, imem_re}, 32'd0);
                sb_pc     = branch_target;
                out_model = 0;
            end else begin
                if (ib_push) begin
                    check("push_entry", ib_push_data, {sb_pc, sb_pc + 16'h1000});
                    check("push_while_full", {31'd0, ib_full}, 32'd0);
                    push_log.push_back(ib_push_data);
                    push_cyc.push_back(cyc);
                    sb_pc = sb_pc + 16'd1;
                    out_model--;
                end
                if (imem_re) begin
                    issue_cnt++;
                    out_model++;
                end
                if (free_run) check("outstanding_le_max", 32'(out_model <= 4), 32'd1);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // Directed sequence.
    initial begin
        int p;
        int c;
        int i0;
        rst_n = 1'b0; ib_full = 1'b0; branch_taken = 1'b0; branch_target = '0;

        // Reset state.
        step(3);
        check("reset_imem_re", {31'd0, imem_re}, 32'd0);
        check("reset_ib_push", {31'd0, ib_push}, 32'd0);
        rst_n = 1'b1;
        c = cyc;

        // Free run, then hold ib_full for 5 edges while words 3.. arrive.
        wait_pushes(3, 20, "first3");
        check("first_push_latency", push_cyc[0] - c, 32'd3);
        check("first3_back_to_back", push_cyc[2] - push_cyc[0], 32'd2);
        check("push0", push_log[0], 32'h0000_1000);
        p = push_log.size();
        ib_full = 1'b1;
        step(5);
        check("full_no_push", push_log.size(), p);
        ib_full = 1'b0;
        wait_pushes(4, 20, "resume");
        check("resume_entry", push_log[3], 32'h0003_1003);
        check("resume_gap", push_cyc[3] - push_cyc[2], 32'd7);
        wait_pushes(15, 40, "steady");
        check("steady_rate", push_cyc[14] - push_cyc[4], 32'd10);

        // Redirect backwards to 0002 with later addresses in flight.
        free_run = 1'b1;
        c = cyc;
        p = push_log.size();
        redirect(16'h0002);
        wait_pushes(p + 1, 20, "redir");
        check("redir_entry", push_log[p], 32'h0002_1002);
        check("redir_latency", push_cyc[p] - c, 32'd4);
        wait_pushes(p + 6, 20, "redir_run");
        free_run = 1'b0;

        // Redirect on the same edge as a matching response.
        for (int k = 0; k < 20 && !(imem_ready && imem_raddr_out == sb_pc); k++) step(1);
        check("collide_found", 32'(imem_ready && imem_raddr_out == sb_pc), 32'd1);
        p = push_log.size();
        redirect(16'h0040);
        check("collide_no_push", {31'd0, ib_push}, 32'd0);
        wait_pushes(p + 1, 20, "collide");
        check("collide_entry", push_log[p], 32'h0040_1040);

        // Back-to-back redirects (last wins) into the address wrap.
        branch_taken  = 1'b1;
        branch_target = 16'h0300;
        step(1);
        p = push_log.size();
        redirect(16'hFFFE);
        wait_pushes(p + 3, 20, "wrap");
        check("wrap_fffe", push_log[p],     32'hFFFE_0FFE);
        check("wrap_ffff", push_log[p + 1], 32'hFFFF_0FFF);
        check("wrap_0000", push_log[p + 2], 32'h0000_1000);

        // No responses: exactly MAX_OUTSTANDING requests go out, then issue stalls.
        mem_mute = 1'b1;
        step(1);
        redirect(16'h0100);
        i0 = issue_cnt;
        step(12);
        check("max_out_issues", issue_cnt - i0, 32'd4);
        check("max_out_model", out_model, 32'd4);
        check("max_out_re_low", {31'd0, imem_re}, 32'd0);

        // Reset mid-stream: outputs clear, the late response is dropped, fetch restarts at 0000.
        mem_mute = 1'b0;
        redirect(16'h0020);
        p = push_log.size();
        wait_pushes(p + 4, 20, "pre_reset");
        rst_n = 1'b0;
        c = cyc;
        step(1);
        rst_n = 1'b1;
        check("midrst_imem_re", {31'd0, imem_re}, 32'd0);
        check("midrst_raddr", {16'd0, imem_raddr}, 32'd0);
        check("midrst_data", ib_push_data, 32'd0);
        p = push_log.size();
        wait_pushes(p + 1, 20, "post_reset");
        check("post_reset_entry", push_log[p], 32'h0000_1000);
        check("post_reset_latency", push_cyc[p] - c, 32'd4);
`ifdef FETCH_STATS_EN
        check("stat_pushed", {16'd0, stat_pushed}, 32'd1);
        check("stat_dropped", {16'd0, stat_dropped}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
